// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan controller: active-high
// segment codes ({a,b,c,d,e,f,g}), converter state type and digit helpers.
package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;

  typedef enum logic [1:0] {
    CVT_IDLE,
    CVT_SHIFT,
    CVT_DONE
  } cvt_state_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'd0:    code = 7'b1111110;
      4'd1:    code = 7'b0110000;
      4'd2:    code = 7'b1101101;
      4'd3:    code = 7'b1111001;
      4'd4:    code = 7'b0110011;
      4'd5:    code = 7'b1011011;
      4'd6:    code = 7'b1011111;
      4'd7:    code = 7'b1110000;
      4'd8:    code = 7'b1111111;
      4'd9:    code = 7'b1111011;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Double-dabble correction applied to each nibble before the shift.
  function automatic logic [3:0] dabble(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: samples i_value when idle, produces
// NUM_DIGITS BCD nibbles, a sticky overflow flag and a one-cycle done strobe.
module bin2bcd_seq
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int VALUE_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [VALUE_W-1:0]      i_value,
  output logic [4*NUM_DIGITS-1:0] o_bcd,
  output logic                    o_ovf,
  output logic                    o_done
);

  localparam int CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
  localparam int BCD_W = 4 * NUM_DIGITS;

  cvt_state_e         r_state;
  logic [VALUE_W-1:0] r_shift;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic [BCD_W-1:0]   w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < NUM_DIGITS; i++)
      w_adj[4*i +: 4] = dabble(r_bcd[4*i +: 4]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= CVT_IDLE;
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        CVT_IDLE: begin
          r_shift <= i_value;
          r_bcd   <= '0;
          r_ovf   <= 1'b0;
          r_cnt   <= CNT_W'(VALUE_W - 1);
          r_state <= CVT_SHIFT;
        end
        CVT_SHIFT: begin
          // A bit leaving the top nibble means the value needs more digits.
          {r_bcd, r_shift} <= {w_adj[BCD_W-2:0], r_shift, 1'b0};
          r_ovf <= r_ovf | w_adj[BCD_W-1];
          if (r_cnt == '0) r_state <= CVT_DONE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        CVT_DONE: r_state <= CVT_IDLE;
        default:  r_state <= CVT_IDLE;
      endcase
    end
  end

  assign o_bcd  = r_bcd;
  assign o_ovf  = r_ovf;
  assign o_done = (r_state == CVT_DONE);

endmodule

// File: rtl/ssd_scan_ctrl.sv
// N-digit multiplexed seven-segment driver with BCD conversion, DP mask,
// overflow dashes and output polarity. Option: LEADING_ZERO_BLANK_EN.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int VALUE_W     = 16,
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [VALUE_W-1:0]    value,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  overflow
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]            SEG_OFF   = {7{ACTIVE_LOW}};

  logic [4*NUM_DIGITS-1:0] w_bcd;
  logic                    w_cvt_ovf;
  logic                    w_done;

  logic [4*NUM_DIGITS-1:0] r_disp;
  logic                    r_ovf;
  logic [PRE_W-1:0]        r_pre;
  logic [IDX_W-1:0]        r_idx;

  logic                    w_tc;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [3:0]              w_nib;
  logic                    w_dp;
  logic                    w_show;
  logic [NUM_DIGITS-1:0]   w_lit;
  logic [NUM_DIGITS-1:0]   w_anode_ah;
  logic [6:0]              w_seg_ah;

  bin2bcd_seq #(
    .NUM_DIGITS (NUM_DIGITS),
    .VALUE_W    (VALUE_W)
  ) u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .i_value (value),
    .o_bcd   (w_bcd),
    .o_ovf   (w_cvt_ovf),
    .o_done  (w_done)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic w_seen;
  // Scan from the top digit down; digit 0 is always lit so zero shows '0'.
  always_comb begin
    w_seen = 1'b0;
    w_lit  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_seen   = w_seen | (r_disp[4*i +: 4] != 4'd0) | (i == 0);
      w_lit[i] = w_seen;
    end
  end
`else
  assign w_lit = '1;
`endif

  always_comb begin
    w_tc = (r_pre == PRE_W'(REFRESH_DIV - 1));
    if (!w_tc)                                 w_idx_nxt = r_idx;
    else if (r_idx == IDX_W'(NUM_DIGITS - 1))  w_idx_nxt = '0;
    else                                       w_idx_nxt = r_idx + 1'b1;

    w_nib      = 4'd0;
    w_dp       = 1'b0;
    w_show     = 1'b0;
    w_anode_ah = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx_nxt == IDX_W'(i)) begin
        w_nib         = r_disp[4*i +: 4];
        w_dp          = dp_mask[i];
        w_show        = w_lit[i];
        w_anode_ah[i] = 1'b1;
      end
    end

    if (r_ovf)        w_seg_ah = SEG_DASH;
    else if (!w_show) w_seg_ah = SEG_BLANK;
    else              w_seg_ah = seg_decode(w_nib);
  end

  // Outputs are registered against the upcoming index so they switch on the advance edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre  <= '0;
      r_idx  <= '0;
      r_disp <= '0;
      r_ovf  <= 1'b0;
      anode  <= ANODE_OFF;
      seg    <= SEG_OFF;
      dp     <= ACTIVE_LOW;
    end else begin
      r_pre <= w_tc ? '0 : r_pre + 1'b1;
      r_idx <= w_idx_nxt;
      if (w_done) begin
        r_disp <= w_bcd;
        r_ovf  <= w_cvt_ovf;
      end
      anode <= w_anode_ah ^ ANODE_OFF;
      seg   <= w_seg_ah ^ SEG_OFF;
      dp    <= w_dp ^ ACTIVE_LOW;
    end
  end

  assign overflow = r_ovf;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl: an 8-digit and a 4-digit instance,
// active-low outputs, four clocks per digit slot.
module tb_ssd_scan_ctrl;

  localparam int VW     = 16;
  localparam int DIV    = 4;
  localparam int PERIOD = VW + 2;

  typedef struct {
    logic [7:0] anode;
    logic [6:0] seg;
    logic       dp;
    logic       ovf;
    string      tag;
    int         idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] value8 = '0, value4 = '0;
  logic [7:0]  mask8 = '0;
  logic [3:0]  mask4 = '0;
  logic [7:0]  anode8;
  logic [3:0]  anode4;
  logic [6:0]  seg8, seg4;
  logic        dp8, dp4, ovf8, ovf4;

  exp_t        q8[$];
  exp_t        q4[$];
  exp_t        m8, m4;
  logic [7:0]  prev8 = 8'hFF;
  logic [3:0]  prev4 = 4'hF;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          e0;
  bit          found;

  // Active-low codes for digits 0-9, hand-derived from the segment table.
  logic [6:0] seg_al [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  localparam logic [6:0] AL_DASH  = 7'b1111110;
  localparam logic [6:0] AL_BLANK = 7'b1111111;

  ssd_scan_ctrl #(.NUM_DIGITS(8), .VALUE_W(VW), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .value(value8), .dp_mask(mask8),
    .anode(anode8), .seg(seg8), .dp(dp8), .overflow(ovf8));

  ssd_scan_ctrl #(.NUM_DIGITS(4), .VALUE_W(VW), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .value(value4), .dp_mask(mask4),
    .anode(anode4), .seg(seg4), .dp(dp4), .overflow(ovf4));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= reset_n ? cyc + 1 : 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endfunction

  function automatic logic [6:0] exp_seg(input int unsigned v, input int idx, input int n);
    int unsigned p;
    int unsigned lim;
    p = 1;
    lim = 1;
    for (int i = 0; i < idx; i++) p *= 10;
    for (int i = 0; i < n; i++) lim *= 10;
    if (v >= lim) return AL_DASH;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && v < p) return AL_BLANK;
`endif
    return seg_al[(v / p) % 10];
  endfunction

  // Monitors: each new digit slot pops one expectation.
  always @(negedge clk) begin
    if (anode8 !== prev8 && q8.size() > 0) begin
      m8 = q8.pop_front();
      chk($sformatf("%s_d%0d", m8.tag, m8.idx), 32'({anode8, seg8, dp8, ovf8}),
          32'({m8.anode, m8.seg, m8.dp, m8.ovf}));
    end
    prev8 = anode8;
  end

  always @(negedge clk) begin
    if (anode4 !== prev4 && q4.size() > 0) begin
      m4 = q4.pop_front();
      chk($sformatf("%s_d%0d", m4.tag, m4.idx), 32'({anode4, seg4, dp4, ovf4}),
          32'({m4.anode[3:0], m4.seg, m4.dp, m4.ovf}));
    end
    prev4 = anode4;
  end

  task automatic expect_scan(input bit sel4, input int unsigned v, input logic [7:0] mask,
                             input string tag);
    int          n;
    int          i;
    int unsigned lim;
    bit          aligned;
    exp_t        e;
    n = sel4 ? 4 : 8;
    lim = 1;
    for (int k = 0; k < n; k++) lim *= 10;
    if (sel4) begin value4 = 16'(v); mask4 = mask[3:0]; end
    else      begin value8 = 16'(v); mask8 = mask;      end
    repeat (2 * PERIOD + 4) @(posedge clk);
    aligned = 1'b0;
    for (int t = 0; t < 200 && !aligned; t++) begin
      @(posedge clk); #1;
      if (sel4) aligned = (anode4 == 4'h7) && (prev4 == 4'h7);
      else      aligned = (anode8 == 8'h7F) && (prev8 == 8'h7F);
    end
    chk({tag, "_align"}, 32'(aligned), 32'd1);
    if (aligned) begin
      for (int k = 0; k <= n; k++) begin
        i = k % n;
        e.anode = ~(8'd1 << i);
        e.seg   = exp_seg(v, i, n);
        e.dp    = ~mask[i];
        e.ovf   = (v >= lim);
        e.tag   = tag;
        e.idx   = i;
        if (sel4) q4.push_back(e);
        else      q8.push_back(e);
      end
      for (int t = 0; t < 100 && (sel4 ? q4.size() : q8.size()) > 0; t++) @(posedge clk);
      chk({tag, "_drain"}, 32'(sel4 ? q4.size() : q8.size()), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_anode8", 32'(anode8), 32'hFF);
    chk("rst_seg8",   32'(seg8),   32'h7F);
    chk("rst_dp8",    32'(dp8),    32'd1);
    chk("rst_ovf8",   32'(ovf8),   32'd0);
    chk("rst_anode4", 32'(anode4), 32'hF);
    chk("rst_seg4",   32'(seg4),   32'h7F);
    chk("rst_dp4",    32'(dp4),    32'd1);
    chk("rst_ovf4",   32'(ovf4),   32'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    expect_scan(1'b0, 0,     8'h00,        "zero8");
    expect_scan(1'b0, 1234,  8'h00,        "v1234");
    expect_scan(1'b0, 1234,  8'b0000_0100, "dp2");
    expect_scan(1'b0, 42,    8'h00,        "v42");
    expect_scan(1'b0, 65535, 8'h81,        "max8");
    expect_scan(1'b1, 65535, 8'h00,        "ovf4");
    expect_scan(1'b1, 9999,  8'h00,        "clr4");
    expect_scan(1'b1, 10000, 8'h00,        "ovf10k");
    expect_scan(1'b1, 907,   8'h02,        "v907");

    // Value change during SHIFT: the new value is sampled at the next IDLE.
    value8 = 16'd5;
    mask8  = 8'h00;
    repeat (2 * PERIOD + 4) @(posedge clk);
    found = 1'b0;
    for (int t = 0; t < 2 * PERIOD && !found; t++) begin
      @(posedge clk); #1;
      found = (cyc % PERIOD == 2);
    end
    chk("mid_shift_sync", 32'(found), 32'd1);
    e0 = cyc;
    value8 = 16'd7;
    // Sampled PERIOD-1 edges later, shown PERIOD edges after that.
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (anode8 == 8'hFE)
        chk($sformatf("hold5to7_k%0d", cyc - e0), 32'(seg8),
            32'((cyc - e0 >= 2 * PERIOD - 1) ? seg_al[7] : seg_al[5]));
    end

    // Asynchronous reset in the middle of digit 2's slot.
    value8 = 16'd1234;
    mask8  = 8'b0000_0100;
    repeat (2 * PERIOD + 4) @(posedge clk);
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(posedge clk); #1;
      found = (anode8 == 8'hFB);
    end
    chk("slot2_found", 32'(found), 32'd1);
    chk("slot2_dp_lit", 32'(dp8), 32'd0);
    chk("slot2_seg", 32'(seg8), 32'(seg_al[2]));
    #1 reset_n = 1'b0;
    #1;
    chk("arst_anode8", 32'(anode8), 32'hFF);
    chk("arst_seg8",   32'(seg8),   32'h7F);
    chk("arst_dp8",    32'(dp8),    32'd1);
    chk("arst_ovf8",   32'(ovf8),   32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_anode", 32'(anode8), 32'hFE);
    chk("post_rst_seg",   32'(seg8),   32'(seg_al[0]));
    chk("post_rst_dp",    32'(dp8),    32'd1);
    repeat (2) @(negedge clk);
    chk("post_rst_slot0_end", 32'(anode8), 32'hFE);
    @(negedge clk);
    chk("post_rst_slot1", 32'(anode8), 32'hFD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
